// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control block: select codes, funct values,
// alu_op codes, multiply/divide kinds and sequencer states.
package alu_ctrl_pkg;

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_ORI   = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_RUN  = 2'd1,
    ST_MD_DONE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Pure combinational decode of alu_op/funct into ALU select, MD kind and
// an illegal flag for unknown R-type function codes.
module alu_ctrl_seq_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] sel,
  output logic       is_md,
  output logic [1:0] md_kind,
  output logic       illegal
);

  always_comb begin
    sel     = SEL_ADD;
    is_md   = 1'b0;
    md_kind = MD_MULT;
    illegal = 1'b0;
    case (alu_op)
      OP_ADD: sel = SEL_ADD;
      OP_SUB: sel = SEL_SUB;
      OP_ORI: sel = SEL_OR;
      default: begin
        case (funct)
          FN_ADD:   sel = SEL_ADD;
          FN_SUB:   sel = SEL_SUB;
          FN_AND:   sel = SEL_AND;
          FN_OR:    sel = SEL_OR;
          FN_SLT:   sel = SEL_SLT;
          FN_MULT:  begin is_md = 1'b1; md_kind = MD_MULT;  end
          FN_MULTU: begin is_md = 1'b1; md_kind = MD_MULTU; end
          FN_DIV:   begin is_md = 1'b1; md_kind = MD_DIV;   end
          FN_DIVU:  begin is_md = 1'b1; md_kind = MD_DIVU;  end
          default:  illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control with a single-entry valid/ready output stage and a sequencer
// for multi-cycle multiply/divide. Optional macro ALU_CTRL_PERF_EN adds perf_md_cyc.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = $clog2(MD_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] alu_sel,
  output logic [1:0]       md_kind,
  output logic             md_init,
  output logic             md_step,
  output logic             hilo_we,
  output logic             illegal,
  output logic             stall
`ifdef ALU_CTRL_PERF_EN
  ,output logic [31:0]     perf_md_cyc
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic [1:0]       md_kind_q, md_kind_d;
  logic             md_init_q, md_init_d;
  logic             md_step_q, md_step_d;
  logic             hilo_we_q, hilo_we_d;
  logic             illegal_q, illegal_d;
  logic             ready_int;
  logic             accept;

  logic [2:0] dec_sel;
  logic       dec_is_md;
  logic [1:0] dec_kind;
  logic       dec_illegal;

  alu_ctrl_seq_decode u_decode (
    .alu_op  (alu_op),
    .funct   (funct),
    .sel     (dec_sel),
    .is_md   (dec_is_md),
    .md_kind (dec_kind),
    .illegal (dec_illegal)
  );

  // Gated by rst_n so every output reads 0 while reset is asserted.
  assign ready_int = (state_q == ST_IDLE) ||
                     (((state_q == ST_HOLD) || (state_q == ST_MD_DONE)) && out_ready);
  assign in_ready  = rst_n && ready_int;
  assign stall     = rst_n && in_valid && !ready_int;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    alu_sel_d   = alu_sel_q;
    md_kind_d   = md_kind_q;
    illegal_d   = illegal_q;
    md_init_d   = 1'b0;
    md_step_d   = 1'b0;
    hilo_we_d   = 1'b0;

    case (state_q)
      ST_MD_RUN: begin
        if (cnt_q == CNT_W'(MD_CYCLES - 1)) begin
          state_d     = ST_MD_DONE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          alu_sel_d   = SEL_W'(SEL_ADD);
          illegal_d   = 1'b0;
          hilo_we_d   = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          md_step_d = 1'b1;
        end
      end
      ST_MD_DONE, ST_HOLD: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          illegal_d   = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: ;
    endcase

    // A new request overrides the completion path, giving back-to-back flow.
    if (accept) begin
      if (dec_is_md) begin
        state_d     = ST_MD_RUN;
        cnt_d       = '0;
        md_kind_d   = dec_kind;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        md_init_d   = 1'b1;
        md_step_d   = 1'b1;
      end else begin
        state_d     = ST_HOLD;
        out_valid_d = 1'b1;
        alu_sel_d   = SEL_W'(dec_sel);
        illegal_d   = dec_illegal;
      end
    end
  end

`ifdef ALU_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;
  always_comb begin
    perf_d = perf_q;
    if (md_step_q && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end
  assign perf_md_cyc = perf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      alu_sel_q   <= '0;
      md_kind_q   <= '0;
      md_init_q   <= 1'b0;
      md_step_q   <= 1'b0;
      hilo_we_q   <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_CTRL_PERF_EN
      perf_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      alu_sel_q   <= alu_sel_d;
      md_kind_q   <= md_kind_d;
      md_init_q   <= md_init_d;
      md_step_q   <= md_step_d;
      hilo_we_q   <= hilo_we_d;
      illegal_q   <= illegal_d;
`ifdef ALU_CTRL_PERF_EN
      perf_q      <= perf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign alu_sel   = alu_sel_q;
  assign md_kind   = md_kind_q;
  assign md_init   = md_init_q;
  assign md_step   = md_step_q;
  assign hilo_we   = hilo_we_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios then random traffic,
// compared each cycle against a transaction-level reference model.
module tb_alu_ctrl_seq;

  localparam int MDC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] alu_sel;
  logic [1:0] md_kind;
  logic       md_init;
  logic       md_step;
  logic       hilo_we;
  logic       illegal;
  logic       stall;
`ifdef ALU_CTRL_PERF_EN
  logic [31:0] perf_md_cyc;
`endif

  alu_ctrl_seq #(.SEL_W(3), .MD_CYCLES(MDC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_sel   (alu_sel),
    .md_kind   (md_kind),
    .md_init   (md_init),
    .md_step   (md_step),
    .hilo_we   (hilo_we),
    .illegal   (illegal),
    .stall     (stall)
`ifdef ALU_CTRL_PERF_EN
    ,.perf_md_cyc (perf_md_cyc)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference model: a presented result, or a number of MD steps still to run.
  bit         has_res;
  bit         res_first;
  int         steps_left;
  logic [2:0] m_sel;
  bit         m_ill;
  logic [1:0] m_kind;
  int         m_perf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_decode(input logic [1:0] op, input logic [5:0] fn,
                            output bit is_md, output logic [1:0] kind,
                            output logic [2:0] sel, output bit ill);
    is_md = 0; kind = 2'b00; sel = 3'b010; ill = 0;
    if (op == 2'b00) sel = 3'b010;
    else if (op == 2'b01) sel = 3'b110;
    else if (op == 2'b11) sel = 3'b001;
    else begin
      case (fn)
        6'b100000: sel = 3'b010;
        6'b100010: sel = 3'b110;
        6'b100100: sel = 3'b000;
        6'b100101: sel = 3'b001;
        6'b101010: sel = 3'b111;
        6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
          is_md = 1;
          kind  = fn[1:0];
        end
        default: ill = 1;
      endcase
    end
  endtask

  task automatic model_reset();
    has_res = 0; res_first = 0; steps_left = 0; m_sel = 3'b0; m_ill = 0;
    m_kind = 2'b0; m_perf = 0;
  endtask

  // Called just after a falling edge: drive, check, then advance across one rising edge.
  task automatic run_cycle(input bit iv, input logic [1:0] op, input logic [5:0] fn, input bit ordy);
    bit         exp_rdy, acc, is_md, ill;
    logic [1:0] kind;
    logic [2:0] sel;
    in_valid = iv; alu_op = op; funct = fn; out_ready = ordy;
    #1;
    exp_rdy = (steps_left == 0) && (!has_res || ordy);
    check_eq("out_valid", out_valid, has_res);
    check_eq("illegal", illegal, has_res && m_ill);
    if (has_res) check_eq("alu_sel", alu_sel, m_sel);
    check_eq("md_step", md_step, steps_left > 0);
    check_eq("md_init", md_init, steps_left == MDC);
    check_eq("hilo_we", hilo_we, has_res && res_first);
    if (steps_left > 0 || res_first) check_eq("md_kind", md_kind, m_kind);
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("stall", stall, iv && !exp_rdy);
`ifdef ALU_CTRL_PERF_EN
    check_eq("perf_md_cyc", perf_md_cyc, m_perf);
`endif
    @(posedge clk);
    acc = iv && exp_rdy;
    if (steps_left > 0) begin
      m_perf++;
      steps_left--;
      if (steps_left == 0) begin
        has_res = 1; res_first = 1; m_sel = 3'b010; m_ill = 0;
      end
    end else if (has_res) begin
      res_first = 0;
      if (ordy) begin
        has_res = 0;
        n_txn++;
        $display("txn %0d done: alu_sel=%b illegal=%0d", n_txn, m_sel, m_ill);
      end
    end
    if (acc) begin
      ref_decode(op, fn, is_md, kind, sel, ill);
      if (is_md) begin
        steps_left = MDC; m_kind = kind; res_first = 0;
      end else begin
        has_res = 1; res_first = 0; m_sel = sel; m_ill = ill;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".out_valid"}, out_valid, 1'b0);
    check_eq({tag, ".alu_sel"}, alu_sel, 3'b0);
    check_eq({tag, ".md_kind"}, md_kind, 2'b0);
    check_eq({tag, ".md_init"}, md_init, 1'b0);
    check_eq({tag, ".md_step"}, md_step, 1'b0);
    check_eq({tag, ".hilo_we"}, hilo_we, 1'b0);
    check_eq({tag, ".illegal"}, illegal, 1'b0);
    check_eq({tag, ".in_ready"}, in_ready, 1'b0);
    check_eq({tag, ".stall"}, stall, 1'b0);
  endtask

  logic [5:0] fn_pool [9];

  initial begin
    logic [5:0] fn;
    int         r;
    fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                6'b011000, 6'b011001, 6'b011010, 6'b011011};
    model_reset();
    in_valid = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("in_ready_after_reset", in_ready, 1'b1);
    @(negedge clk);

    // Back-to-back subtracts
    for (int i = 0; i < 3; i++) run_cycle(1, 2'b10, 6'b100010, 1);
    run_cycle(0, 2'b00, 6'b0, 1);
    // Divide with in_valid held through the run
    for (int i = 0; i < 6; i++) run_cycle(1, 2'b10, 6'b011010, 1);
    for (int i = 0; i < 6; i++) run_cycle(0, 2'b00, 6'b0, 1);
    // Add stalled by the consumer for 3 cycles
    run_cycle(1, 2'b00, 6'b0, 0);
    for (int i = 0; i < 3; i++) run_cycle(0, 2'b00, 6'b0, 0);
    run_cycle(0, 2'b00, 6'b0, 1);
    // Illegal funct, then or-immediate with arbitrary funct
    run_cycle(1, 2'b10, 6'b111111, 1);
    run_cycle(1, 2'b11, 6'b011010, 1);
    run_cycle(0, 2'b00, 6'b0, 1);
    // MD completion held by the consumer
    run_cycle(1, 2'b10, 6'b011001, 0);
    for (int i = 0; i < 7; i++) run_cycle(0, 2'b00, 6'b0, 0);
    run_cycle(0, 2'b00, 6'b0, 1);

    // Reset in the middle of an MD run (step counter at 2)
    run_cycle(1, 2'b10, 6'b011011, 1);
    run_cycle(0, 2'b00, 6'b0, 1);
    run_cycle(0, 2'b00, 6'b0, 1);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_md_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(1, 2'b00, 6'b0, 1);
    run_cycle(0, 2'b00, 6'b0, 1);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      if (r == 9) fn = 6'($urandom);
      else fn = fn_pool[r];
      run_cycle($urandom_range(0, 9) < 7, 2'($urandom), fn, $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < MDC + 3; i++) run_cycle(0, 2'b00, 6'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
